// File: rtl/uart_rx_cmd.sv
// rtl/uart_rx_cmd.sv - 8N1 UART receiver with two-byte header+opcode command decoder
module uart_rx_cmd #(
    parameter int         BAUDRATE    = 115200,
    parameter int         FREQ        = 50_000_000,
    parameter int         N_data      = 8,
    parameter logic [7:0] CMD_HEADER  = 8'hA5,
    parameter int         CMD_TIMEOUT = 100_000
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              rx,
    output logic [N_data-1:0] rdata,
    output logic              rvalid,
    output logic              frame_err,
    output logic              start_capture,
    output logic              calib_ena,
    output logic              soft_rst,
    output logic              cmd_err
);

    localparam int BIT_PERIOD  = FREQ / BAUDRATE;
    localparam int HALF_PERIOD = BIT_PERIOD / 2;
    localparam int BCW         = (N_data > 1) ? $clog2(N_data) : 1;

    localparam logic [15:0]       BIT_LAST  = 16'(BIT_PERIOD - 1);
    localparam logic [15:0]       HALF_LAST = 16'(HALF_PERIOD - 1);
    localparam logic [BCW-1:0]    LAST_BIT  = BCW'(N_data - 1);
    localparam logic [31:0]       TMO_LAST  = 32'(CMD_TIMEOUT - 1);

    localparam logic [N_data-1:0] OP_HDR    = N_data'(CMD_HEADER);
    localparam logic [N_data-1:0] OP_START  = N_data'(1);
    localparam logic [N_data-1:0] OP_CAL_ON = N_data'(2);
    localparam logic [N_data-1:0] OP_CAL_OF = N_data'(3);
    localparam logic [N_data-1:0] OP_SRST   = N_data'(4);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    typedef enum logic {
        CMD_IDLE,
        CMD_ARG
    } cmd_state_e;

    // ------------------------------------------------------------------
    // rx synchronizer and falling-edge detection
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_dly_q;
    logic rx_fall;

    // Two-flop synchronizer plus a delayed copy; idle-high so reset to 1
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_dly_q  <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_dly_q  <= rx_s_q;
        end
    end

    assign rx_fall = rx_dly_q & ~rx_s_q;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_e         rx_state_q, rx_state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [N_data-1:0] shift_q, shift_d;
    logic [N_data-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              frame_err_q, frame_err_d;

    // Receiver state, bit timer, shift register and registered outputs
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Frame sequencing: half-bit to the start-bit centre, then whole bits
    always_comb begin
        rx_state_d  = rx_state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    cnt_d      = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        bit_cnt_d  = '0;
                        rx_state_d = RX_DATA;
                    end else begin
                        // Low pulse shorter than half a bit: treat as a glitch
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[N_data-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        rdata_d    = shift_q;
                        rvalid_d   = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        // Bad stop bit: report once and wait out any break
                        frame_err_d = 1'b1;
                        rx_state_d  = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command decoder
    // ------------------------------------------------------------------
    cmd_state_e  cmd_state_q, cmd_state_d;
    logic [31:0] tmo_q, tmo_d;
    logic        start_capture_q, start_capture_d;
    logic        calib_ena_q, calib_ena_d;
    logic        soft_rst_q, soft_rst_d;
    logic        cmd_err_q, cmd_err_d;

    // Decoder state, header timeout counter and decoded control outputs
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            cmd_state_q     <= CMD_IDLE;
            tmo_q           <= '0;
            start_capture_q <= 1'b0;
            calib_ena_q     <= 1'b0;
            soft_rst_q      <= 1'b0;
            cmd_err_q       <= 1'b0;
        end else begin
            cmd_state_q     <= cmd_state_d;
            tmo_q           <= tmo_d;
            start_capture_q <= start_capture_d;
            calib_ena_q     <= calib_ena_d;
            soft_rst_q      <= soft_rst_d;
            cmd_err_q       <= cmd_err_d;
        end
    end

    // Header/opcode decode; a received opcode takes priority over timeout
    always_comb begin
        cmd_state_d     = cmd_state_q;
        tmo_d           = tmo_q;
        start_capture_d = 1'b0;
        calib_ena_d     = calib_ena_q;
        soft_rst_d      = 1'b0;
        cmd_err_d       = 1'b0;
        case (cmd_state_q)
            CMD_IDLE: begin
                if (rvalid_q && (rdata_q == OP_HDR)) begin
                    tmo_d       = '0;
                    cmd_state_d = CMD_ARG;
                end
            end
            CMD_ARG: begin
                if (rvalid_q) begin
                    if (rdata_q == OP_HDR) begin
                        // Repeated header re-arms rather than erroring
                        tmo_d = '0;
                    end else begin
                        cmd_state_d = CMD_IDLE;
                        if (rdata_q == OP_START) begin
                            start_capture_d = 1'b1;
                        end else if (rdata_q == OP_CAL_ON) begin
                            calib_ena_d = 1'b1;
                        end else if (rdata_q == OP_CAL_OF) begin
                            calib_ena_d = 1'b0;
                        end else if (rdata_q == OP_SRST) begin
                            soft_rst_d = 1'b1;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end
                end else if (frame_err_q) begin
                    cmd_state_d = CMD_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    cmd_err_d   = 1'b1;
                    cmd_state_d = CMD_IDLE;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            default: begin
                cmd_state_d = CMD_IDLE;
            end
        endcase
    end

    assign rdata         = rdata_q;
    assign rvalid        = rvalid_q;
    assign frame_err     = frame_err_q;
    assign start_capture = start_capture_q;
    assign calib_ena     = calib_ena_q;
    assign soft_rst      = soft_rst_q;
    assign cmd_err       = cmd_err_q;

endmodule
